systolic_feeder: RTL and testbench

- Parametrised operand front-end for the tiny TPU systolic array.
- Accepts X-row and Y-column operands over narrow serial lanes (SW bits/beat) with a valid/ready handshake, and assembles them into D_W-bit words.
- Stores the words in N per-lane banks of depth K, then replays all banks into the array with the diagonal skew the array expects.
- Adds over the previous loader: configurable serial width, configurable depth, per-lane valid, a done pulse, clear, and operand reuse across multiple feeds.

---
 rtl/systolic_feeder.sv | 221 ++++++++++++++++++++++
 tb/tb_systolic_feeder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// systolic_feeder: serial operand loader and skewed replay front-end for the
// systolic array. X and Y words arrive SW bits per beat (LSB-first), are
// assembled into D_W-bit words, stored lane-major in N banks of depth K, and
// replayed with a one-cycle skew per lane.
module systolic_feeder #(
    parameter int D_W = 8,
    parameter int N   = 2,
    parameter int K   = 2,
    parameter int SW  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SW-1:0]    ser_x,
    input  logic [SW-1:0]    ser_y,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             start,
    input  logic             reuse,
    input  logic             clear,
    output logic             busy,
    output logic             full,
    output logic             done,
    output logic [N-1:0]     out_valid,
    output logic [N*D_W-1:0] out_x_flat,
    output logic [N*D_W-1:0] out_y_flat,
    output logic             out_init
);

    localparam int BEATS = D_W / SW;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int AW    = (K > 1) ? $clog2(K) : 1;
    localparam int LW    = $clog2(N);
    localparam int FW    = $clog2(K + N);

    localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(K - 1);
    localparam logic [LW-1:0] LANE_LAST = LW'(N - 1);
    localparam logic [FW-1:0] FEED_LAST = FW'(K + N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FEED = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [BW-1:0]  beat_q,  beat_d;
    logic [AW-1:0]  addr_q,  addr_d;
    logic [LW-1:0]  lane_q,  lane_d;
    logic           full_q,  full_d;
    logic [D_W-1:0] shx_q,   shx_d;
    logic [D_W-1:0] shy_q,   shy_d;
    logic [FW-1:0]  fcnt_q,  fcnt_d;
    logic           reuse_q, reuse_d;
    logic           done_q,  done_d;
    logic           init_q,  init_d;
    logic           wr_en;

    logic [D_W-1:0] asm_x;
    logic [D_W-1:0] asm_y;

    // Operand storage; contents are only ever read while full is set.
    logic [D_W-1:0] bank_x_q [N][K];
    logic [D_W-1:0] bank_y_q [N][K];

    // New beat enters at the MSB end so the first beat ends up in the LSBs.
    assign asm_x = D_W'({ser_x, shx_q} >> SW);
    assign asm_y = D_W'({ser_y, shy_q} >> SW);

    assign load_ready = (state_q == IDLE) && !full_q;
    assign busy       = (state_q == FEED);
    assign full       = full_q;
    assign done       = done_q;
    assign out_init   = init_q;

    // Next-state and counter logic: loading and clear in IDLE, replay timing in FEED.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        lane_d  = lane_q;
        full_d  = full_q;
        shx_d   = shx_q;
        shy_d   = shy_q;
        fcnt_d  = fcnt_q;
        reuse_d = reuse_q;
        done_d  = 1'b0;
        init_d  = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    beat_d = '0;
                    addr_d = '0;
                    lane_d = '0;
                    shx_d  = '0;
                    shy_d  = '0;
                    full_d = 1'b0;
                end else if (start && full_q) begin
                    state_d = FEED;
                    fcnt_d  = '0;
                    reuse_d = reuse;
                end else if (load_valid && !full_q) begin
                    shx_d = asm_x;
                    shy_d = asm_y;
                    if (beat_q == BEAT_LAST) begin
                        beat_d = '0;
                        wr_en  = 1'b1;
                        if (addr_q == ADDR_LAST) begin
                            addr_d = '0;
                            if (lane_q == LANE_LAST) begin
                                lane_d = '0;
                                full_d = 1'b1;
                            end else begin
                                lane_d = lane_q + 1'b1;
                            end
                        end else begin
                            addr_d = addr_q + 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            FEED: begin
                init_d = (fcnt_q == '0);
                if (fcnt_q == FEED_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    fcnt_d  = '0;
                    if (!reuse_q) begin
                        full_d = 1'b0;
                        beat_d = '0;
                        addr_d = '0;
                        lane_d = '0;
                        shx_d  = '0;
                        shy_d  = '0;
                    end
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and assembly registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            lane_q  <= '0;
            full_q  <= 1'b0;
            shx_q   <= '0;
            shy_q   <= '0;
            fcnt_q  <= '0;
            reuse_q <= 1'b0;
            done_q  <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            lane_q  <= lane_d;
            full_q  <= full_d;
            shx_q   <= shx_d;
            shy_q   <= shy_d;
            fcnt_q  <= fcnt_d;
            reuse_q <= reuse_d;
            done_q  <= done_d;
            init_q  <= init_d;
        end
    end

    // Bank write of a completed word pair, lane-major order.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            bank_x_q[lane_q][addr_q] <= asm_x;
            bank_y_q[lane_q][addr_q] <= asm_y;
        end
    end

    // Per-lane skewed replay: lane g presents word (fcnt - g) while that index is in 0..K-1.
    for (genvar g = 0; g < N; g++) begin : g_lane
        int             t;
        logic           in_win;
        logic [AW-1:0]  rd_addr;
        logic           vld_q;
        logic [D_W-1:0] x_q;
        logic [D_W-1:0] y_q;

        // Window decode for this lane from the shared feed counter.
        always_comb begin
            t       = int'(fcnt_q) - g;
            in_win  = (state_q == FEED) && (t >= 0) && (t < K);
            rd_addr = AW'(t);
        end

        // Registered lane output; zero outside the lane's window.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                x_q   <= '0;
                y_q   <= '0;
            end else if (in_win) begin
                vld_q <= 1'b1;
                x_q   <= bank_x_q[g][rd_addr];
                y_q   <= bank_y_q[g][rd_addr];
            end else begin
                vld_q <= 1'b0;
                x_q   <= '0;
                y_q   <= '0;
            end
        end

        assign out_valid[g]              = vld_q;
        assign out_x_flat[g*D_W +: D_W]  = x_q;
        assign out_y_flat[g*D_W +: D_W]  = y_q;
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: two instances (N=2,K=2,SW=1 and N=4,K=3,SW=2)
// driven through a shared stimulus path, checked against an array model of
// the stored words and the skewed replay schedule.
module tb_systolic_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, sel, load_valid, start, reuse, clear;
    logic [1:0] ser_x, ser_y;

    logic        a_ready, a_busy, a_full, a_done, a_init;
    logic [1:0]  a_valid;
    logic [15:0] a_x, a_y;

    logic        b_ready, b_busy, b_full, b_done, b_init;
    logic [3:0]  b_valid;
    logic [31:0] b_x, b_y;

    systolic_feeder #(.D_W(8), .N(2), .K(2), .SW(1)) dut_a (
        .clk(clk), .rst(rst), .ser_x(ser_x[0:0]), .ser_y(ser_y[0:0]),
        .load_valid(load_valid & ~sel), .load_ready(a_ready),
        .start(start & ~sel), .reuse(reuse), .clear(clear & ~sel),
        .busy(a_busy), .full(a_full), .done(a_done), .out_valid(a_valid),
        .out_x_flat(a_x), .out_y_flat(a_y), .out_init(a_init)
    );

    systolic_feeder #(.D_W(8), .N(4), .K(3), .SW(2)) dut_b (
        .clk(clk), .rst(rst), .ser_x(ser_x), .ser_y(ser_y),
        .load_valid(load_valid & sel), .load_ready(b_ready),
        .start(start & sel), .reuse(reuse), .clear(clear & sel),
        .busy(b_busy), .full(b_full), .done(b_done), .out_valid(b_valid),
        .out_x_flat(b_x), .out_y_flat(b_y), .out_init(b_init)
    );

    wire        g_ready = sel ? b_ready : a_ready;
    wire        g_busy  = sel ? b_busy  : a_busy;
    wire        g_full  = sel ? b_full  : a_full;
    wire        g_done  = sel ? b_done  : a_done;
    wire        g_init  = sel ? b_init  : a_init;
    wire [3:0]  g_valid = sel ? b_valid : {2'b00, a_valid};
    wire [31:0] g_x     = sel ? b_x     : {16'h0, a_x};
    wire [31:0] g_y     = sel ? b_y     : {16'h0, a_y};

    int         n_chk = 0;
    int         n_fail = 0;
    int         cur_n, cur_k, cur_sw;
    logic [7:0] ref_x [16];
    logic [7:0] ref_y [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [7:0] x, input logic [7:0] y, input int mode);
        int         beats;
        logic [7:0] mask;
        beats = 8 / cur_sw;
        mask  = 8'((1 << cur_sw) - 1);
        for (int b = 0; b < beats; b++) begin
            ser_x      = 2'((x >> (b * cur_sw)) & mask);
            ser_y      = 2'((y >> (b * cur_sw)) & mask);
            load_valid = 1'b1;
            tick();
            if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) begin
                load_valid = 1'b0;
                ser_x      = 2'($urandom);
                ser_y      = 2'($urandom);
                tick();
            end
        end
        load_valid = 1'b0;
    endtask

    task automatic load_all(input int mode, input string tag);
        for (int w = 0; w < cur_n * cur_k; w++) begin
            chk({tag, " full_before_last"}, 64'(g_full), 64'(0));
            send_word(ref_x[4'(w)], ref_y[4'(w)], mode);
            if (mode == 1 && w == 1) repeat (3) tick();
        end
        chk({tag, " full_after_load"}, 64'(g_full), 64'(1));
        chk({tag, " ready_when_full"}, 64'(g_ready), 64'(0));
    endtask

    task automatic feed(input logic reuse_v, input logic chain, input string tag);
        logic [3:0]  ev;
        logic [31:0] ex, ey;
        int          t;
        start = 1'b1;
        reuse = reuse_v;
        tick();
        start = 1'b0;
        chk({tag, " busy_at_c"}, 64'(g_busy), 64'(1));
        chk({tag, " valid_at_c"}, 64'(g_valid), 64'(0));
        for (int j = 1; j <= cur_n + cur_k; j++) begin
            tick();
            ev = '0;
            ex = '0;
            ey = '0;
            for (int lane = 0; lane < cur_n; lane++) begin
                t = j - 1 - lane;
                if (t >= 0 && t < cur_k) begin
                    ev = ev | 4'(1 << lane);
                    ex = ex | (32'(ref_x[4'(lane * cur_k + t)]) << (lane * 8));
                    ey = ey | (32'(ref_y[4'(lane * cur_k + t)]) << (lane * 8));
                end
            end
            chk($sformatf("%s valid j=%0d", tag, j), 64'(g_valid), 64'(ev));
            chk($sformatf("%s x j=%0d", tag, j), 64'(g_x), 64'(ex));
            chk($sformatf("%s y j=%0d", tag, j), 64'(g_y), 64'(ey));
            chk($sformatf("%s init j=%0d", tag, j), 64'(g_init), 64'(j == 1));
            chk($sformatf("%s done j=%0d", tag, j), 64'(g_done), 64'(j == cur_n + cur_k));
            chk($sformatf("%s busy j=%0d", tag, j), 64'(g_busy), 64'(j < cur_n + cur_k));
            chk($sformatf("%s full j=%0d", tag, j), 64'(g_full),
                64'((j < cur_n + cur_k) ? 1'b1 : reuse_v));
        end
        if (chain) begin
            start = 1'b1;
            reuse = 1'b1;
        end
    endtask

    task automatic set_a();
        sel = 1'b0; cur_n = 2; cur_k = 2; cur_sw = 1;
    endtask

    task automatic rand_refs();
        for (int w = 0; w < 16; w++) begin
            ref_x[4'(w)] = 8'($urandom);
            ref_y[4'(w)] = 8'($urandom);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout n_chk=%0d", n_chk);
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        rst = 1'b1; load_valid = 1'b0; start = 1'b0; reuse = 1'b0; clear = 1'b0;
        ser_x = '0; ser_y = '0;
        set_a();
        tick();
        tick();
        chk("rst ready", 64'(g_ready), 64'(1));
        chk("rst busy", 64'(g_busy), 64'(0));
        chk("rst full", 64'(g_full), 64'(0));
        chk("rst done", 64'(g_done), 64'(0));
        chk("rst valid", 64'(g_valid), 64'(0));
        chk("rst x", 64'(g_x), 64'(0));
        chk("rst y", 64'(g_y), 64'(0));
        chk("rst init", 64'(g_init), 64'(0));
        rst = 1'b0;
        tick();

        // start without full data is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_not_full busy", 64'(g_busy), 64'(0));
        tick();
        chk("start_not_full busy2", 64'(g_busy), 64'(0));

        // directed load, beats offered while full are dropped
        ref_x[0] = 8'h11; ref_x[1] = 8'h22; ref_x[2] = 8'h33; ref_x[3] = 8'h44;
        ref_y[0] = 8'hA1; ref_y[1] = 8'hA2; ref_y[2] = 8'hA3; ref_y[3] = 8'hA4;
        load_all(0, "dir");
        load_valid = 1'b1;
        ser_x = 2'b11;
        ser_y = 2'b11;
        repeat (4) begin
            tick();
            chk("offer_full ready", 64'(g_ready), 64'(0));
            chk("offer_full full", 64'(g_full), 64'(1));
        end
        load_valid = 1'b0;
        feed(1'b1, 1'b1, "dir_reuse1");
        feed(1'b1, 1'b0, "dir_reuse2");
        feed(1'b0, 1'b0, "dir_noreuse");
        tick();
        chk("after_noreuse full", 64'(g_full), 64'(0));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("after_noreuse start busy", 64'(g_busy), 64'(0));

        // partial word then clear (same cycle as a beat), then gapped reload
        load_valid = 1'b1;
        ser_x = 2'b01;
        ser_y = 2'b01;
        repeat (5) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        load_valid = 1'b0;
        chk("clear full", 64'(g_full), 64'(0));
        chk("clear ready", 64'(g_ready), 64'(1));
        load_all(1, "gapped");
        feed(1'b0, 1'b0, "gapped");

        // random data with random gaps; first round also checks clear drops full
        for (int r = 0; r < 3; r++) begin
            rand_refs();
            load_all(2, "rnd");
            if (r == 0) begin
                clear = 1'b1;
                tick();
                clear = 1'b0;
                chk("clear_when_full full", 64'(g_full), 64'(0));
                chk("clear_when_full ready", 64'(g_ready), 64'(1));
                load_all(2, "rnd_reload");
            end
            feed(1'b0, 1'b0, "rnd");
        end

        // second parameter set: N=4, K=3, SW=2
        sel = 1'b1; cur_n = 4; cur_k = 3; cur_sw = 2;
        tick();
        chk("b idle ready", 64'(g_ready), 64'(1));
        base = $urandom_range(0, 200);
        for (int w = 0; w < 12; w++) begin
            ref_x[4'(w)] = 8'(base + w);
            ref_y[4'(w)] = 8'(base + 8'h40 + w);
        end
        load_all(0, "b_inc");
        feed(1'b1, 1'b0, "b_inc_reuse");
        feed(1'b0, 1'b0, "b_inc");
        rand_refs();
        load_all(2, "b_rnd");
        feed(1'b0, 1'b0, "b_rnd");

        // reset in the middle of a feed
        set_a();
        tick();
        rand_refs();
        load_all(0, "rstfeed");
        start = 1'b1;
        reuse = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst valid", 64'(g_valid), 64'(0));
        chk("midrst busy", 64'(g_busy), 64'(0));
        chk("midrst full", 64'(g_full), 64'(0));
        chk("midrst ready", 64'(g_ready), 64'(1));
        chk("midrst done", 64'(g_done), 64'(0));
        repeat (6) begin
            tick();
            chk("midrst no_done", 64'(g_done), 64'(0));
            chk("midrst no_busy", 64'(g_busy), 64'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
